// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU; macro ALU_MUL_EN enables the iterative multiplier
module alu_mc #(
  parameter int word = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      alu_op,
  input  logic [word-1:0] A,
  input  logic [word-1:0] bus,
  output logic [word-1:0] G,
  output logic            done,
  output logic            busy,
  output logic            zf,
  output logic            nf,
  output logic            cf
);

  localparam int SW = $clog2(word);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  // single-cycle result and carry, ready to be captured on an accepted start
  logic [word-1:0] res_d;
  logic            cf_d;

  // registered outputs; they only change in a done cycle
  logic [word-1:0] g_q;
  logic            done_q;
  logic            zf_q;
  logic            nf_q;
  logic            cf_q;

  // decode the single-cycle operations; op 111 falls to the default (zero) here
  always_comb begin
    res_d = '0;
    cf_d  = 1'b0;
    case (alu_op)
      OP_NOP: res_d = '0;
      OP_ADD: {cf_d, res_d} = {1'b0, A} + {1'b0, bus};
      OP_SUB: begin
        res_d = A - bus;
        cf_d  = (A < bus);
      end
      OP_AND: res_d = A & bus;
      OP_OR:  res_d = A | bus;
      OP_XOR: res_d = A ^ bus;
      OP_SHL: res_d = A << bus[SW-1:0];
      default: begin
        res_d = '0;
        cf_d  = 1'b0;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t          state_q;
  logic            busy_q;
  logic [SW-1:0]   cnt_q;
  logic [word-1:0] mcand_q;
  logic [word-1:0] mplier_q;
  logic [word-1:0] prod_q;

  // control FSM: single-cycle ops retire from IDLE, MUL runs shift-and-add for word cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      g_q      <= '0;
      done_q   <= 1'b0;
      zf_q     <= 1'b1;
      nf_q     <= 1'b0;
      cf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (alu_op == OP_MUL) begin
              mcand_q  <= A;
              mplier_q <= bus;
              prod_q   <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= MUL;
            end else begin
              g_q    <= res_d;
              zf_q   <= (res_d == '0);
              nf_q   <= res_d[word-1];
              cf_q   <= cf_d;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          // bits shifted out of the multiplicand only affect weights >= 2^word
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SW'(1);
          if (cnt_q == SW'(word - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          // a start seen here is dropped: busy is still high this cycle
          g_q     <= prod_q;
          zf_q    <= (prod_q == '0);
          nf_q    <= prod_q[word-1];
          cf_q    <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
`else
  // without the multiplier every op, including 111, retires one cycle after start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q    <= '0;
      done_q <= 1'b0;
      zf_q   <= 1'b1;
      nf_q   <= 1'b0;
      cf_q   <= 1'b0;
    end else begin
      done_q <= start;
      if (start) begin
        g_q  <= res_d;
        zf_q <= (res_d == '0);
        nf_q <= res_d[word-1];
        cf_q <= cf_d;
      end
    end
  end

  assign busy = 1'b0;
`endif

  assign G    = g_q;
  assign done = done_q;
  assign zf   = zf_q;
  assign nf   = nf_q;
  assign cf   = cf_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc (word = 16), both ALU_MUL_EN builds
module tb_alu_mc;

  typedef struct packed {
    logic [15:0] g;
    logic        zf;
    logic        nf;
    logic        cf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  alu_op;
  logic [15:0] a_s;
  logic [15:0] bus_s;
  logic [15:0] g;
  logic        done;
  logic        busy;
  logic        zf;
  logic        nf;
  logic        cf;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  alu_mc #(.word(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .alu_op (alu_op),
    .A      (a_s),
    .bus    (bus_s),
    .G      (g),
    .done   (done),
    .busy   (busy),
    .zf     (zf),
    .nf     (nf),
    .cf     (cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned x;
    int unsigned y;
    int unsigned r;
    logic        c;
    exp_t        e;
    x = a;
    y = b;
    r = 0;
    c = 1'b0;
    case (op)
      3'd1: begin r = x + y; c = (r > 32'hFFFF); end
      3'd2: begin r = x + 32'h10000 - y; c = (x < y); end
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = x << (y % 16);
`ifdef ALU_MUL_EN
      3'd7: r = x * y;
`endif
      default: r = 0;
    endcase
    e.g  = r[15:0];
    e.zf = (r[15:0] == 16'h0000);
    e.nf = r[15];
    e.cf = c;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    alu_op = op;
    a_s    = a;
    bus_s  = b;
    start  = 1'b1;
    sb.push_back(model(op, a, b));
  endtask

  task automatic test_reset();
    exp_t e;
    total++;
    if ({g, zf, nf, cf, done, busy} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got g=%h zf=%b nf=%b cf=%b done=%b busy=%b want g=0000 zf=1 nf=0 cf=0 done=0 busy=0",
               g, zf, nf, cf, done, busy);
    end
    issue(3'd2, 16'h0001, 16'h0002);
    @(posedge clk); #1;
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if ({done, g, zf, nf, cf} !== {1'b1, e.g, e.zf, e.nf, e.cf}) begin
      bad++;
      $display("FAIL pre_reset_sub got done=%b g=%h zf=%b nf=%b cf=%b want done=1 g=%h zf=%b nf=%b cf=%b",
               done, g, zf, nf, cf, e.g, e.zf, e.nf, e.cf);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({g, zf, nf, cf, done, busy} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got g=%h zf=%b nf=%b cf=%b done=%b busy=%b want g=0000 zf=1 nf=0 cf=0 done=0 busy=0",
               g, zf, nf, cf, done, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    exp_t e;
    issue(3'd1, 16'hFFFF, 16'h0001);
    @(posedge clk); #1;
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if ({done, g, zf, nf, cf} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_wrap got done=%b g=%h zf=%b nf=%b cf=%b want done=1 g=0000 zf=1 nf=0 cf=1",
               done, g, zf, nf, cf);
    end
    total++;
    if ({g, zf, nf, cf} !== {e.g, e.zf, e.nf, e.cf}) begin
      bad++;
      $display("FAIL add_model got g=%h flags=%b%b%b want g=%h flags=%b%b%b", g, zf, nf, cf, e.g, e.zf, e.nf, e.cf);
    end
    issue(3'd2, 16'h0003, 16'h0005);
    @(posedge clk); #1;
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if ({done, g, zf, nf, cf} !== {1'b1, e.g, e.zf, e.nf, e.cf}) begin
      bad++;
      $display("FAIL sub_borrow got done=%b g=%h zf=%b nf=%b cf=%b want done=1 g=%h zf=%b nf=%b cf=%b",
               done, g, zf, nf, cf, e.g, e.zf, e.nf, e.cf);
    end
    @(posedge clk); #1;
    total++;
    if ({done, g, nf, cf} !== {1'b0, 16'hFFFE, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_hold got done=%b g=%h nf=%b cf=%b want done=0 g=fffe nf=1 cf=1", done, g, nf, cf);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [4] = '{3'd3, 3'd4, 3'd5, 3'd6};
    logic [15:0] as  [4] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h8001};
    logic [15:0] bs  [4] = '{16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h0013};
    logic [15:0] lit [4] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0008};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if ({done, busy, g} !== {1'b1, 1'b0, lit[i]}) begin
        bad++;
        $display("FAIL b2b_%0d got done=%b busy=%b g=%h want done=1 busy=0 g=%h", i, done, busy, g, lit[i]);
      end
      total++;
      if ({g, zf, nf, cf} !== {e.g, e.zf, e.nf, e.cf}) begin
        bad++;
        $display("FAIL b2b_flags_%0d got g=%h flags=%b%b%b want g=%h flags=%b%b%b",
                 i, g, zf, nf, cf, e.g, e.zf, e.nf, e.cf);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done_drop got done=%b want 0", done);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    logic [15:0] as  [2] = '{16'h0123, 16'hFFFF};
    logic [15:0] bs  [2] = '{16'h0010, 16'hFFFF};
    logic [15:0] lit [2] = '{16'h1230, 16'h0001};
    exp_t e;
    int   cycles;
    int   extra;
    logic got;
    logic busy_bad;
    for (int v = 0; v < 2; v++) begin
      issue(3'd7, as[v], bs[v]);
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL mul_busy_rise_%0d got busy=%b want 1", v, busy);
      end
      cycles   = 0;
      got      = 1'b0;
      busy_bad = 1'b0;
      while (!got && cycles < 40) begin
        start  = (v == 0) && (cycles < 6);
        alu_op = 3'd1;
        a_s    = 16'h1111;
        bus_s  = 16'h2222;
        @(posedge clk); #1;
        cycles++;
        if (done === 1'b1) got = 1'b1;
        else if (busy !== 1'b1) busy_bad = 1'b1;
      end
      start = 1'b0;
      e = sb.pop_front();
      total++;
      if ({got, cycles} !== {1'b1, 17}) begin
        bad++;
        $display("FAIL mul_latency_%0d got done_seen=%b cycles=%0d want done_seen=1 cycles=17", v, got, cycles);
      end
      total++;
      if ({busy_bad, busy} !== 2'b00) begin
        bad++;
        $display("FAIL mul_busy_%0d got dropped_early=%b busy_at_done=%b want 0 0", v, busy_bad, busy);
      end
      total++;
      if ({g, zf, nf, cf} !== {lit[v], e.zf, e.nf, e.cf} || e.g !== lit[v]) begin
        bad++;
        $display("FAIL mul_result_%0d got g=%h flags=%b%b%b want g=%h flags=%b%b%b",
                 v, g, zf, nf, cf, lit[v], e.zf, e.nf, e.cf);
      end
      extra = 0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra++;
      end
      total++;
      if (extra !== 0) begin
        bad++;
        $display("FAIL mul_single_done_%0d got extra_done=%0d want 0", v, extra);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int   seen;
    alu_op = 3'd7;
    a_s    = 16'h00FF;
    bus_s  = 16'h0101;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, g, zf} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL mid_mul_reset got busy=%b done=%b g=%h zf=%b want busy=0 done=0 g=0000 zf=1", busy, done, g, zf);
    end
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_mul_no_done got active_cycles=%0d want 0", seen);
    end
    issue(3'd1, 16'h0002, 16'h0003);
    @(posedge clk); #1;
    start = 1'b0;
    e = sb.pop_front();
    total++;
    if ({done, g, zf, nf, cf} !== {1'b1, e.g, e.zf, e.nf, e.cf} || g !== 16'h0005) begin
      bad++;
      $display("FAIL post_reset_add got done=%b g=%h want done=1 g=0005", done, g);
    end
  endtask
`else
  task automatic test_op7_nop();
    exp_t e;
    logic busy_seen;
    issue(3'd7, 16'h0003, 16'h0004);
    busy_seen = busy;
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy_seen | busy;
    e = sb.pop_front();
    total++;
    if ({done, g, zf, nf, cf} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL op7_nop got done=%b g=%h zf=%b nf=%b cf=%b want done=1 g=0000 zf=1 nf=0 cf=0",
               done, g, zf, nf, cf);
    end
    total++;
    if ({g, zf, nf, cf} !== {e.g, e.zf, e.nf, e.cf}) begin
      bad++;
      $display("FAIL op7_model got g=%h want g=%h", g, e.g);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      busy_seen = busy_seen | busy;
    end
    total++;
    if (busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL op7_busy got busy_seen=%b want 0", busy_seen);
    end
  endtask
`endif

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    alu_op = 3'd0;
    a_s    = 16'h0000;
    bus_s  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_add_sub();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_op7_nop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, registered successor to the CPU's combinational datapath ALU. Takes an operation and two operands (accumulator `A` and the shared `bus`), produces a registered result `G` with status flags, and signals completion with a one-cycle `done` pulse. Single-cycle ops complete one clock after `start`; the optional iterative multiplier occupies the unit for `word` cycles. Sits between the accumulator/bus and the G register; the control FSM issues `start` and waits for `done`.

## Interface
- `word`, 16, operand/result width in bits (≥ 4, power of two)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  issue request; sampled only while `busy` = 0
- `alu_op`  in  3  operation code, sampled with `start`
- `A`  in  word  first operand (accumulator), sampled with `start`
- `bus`  in  word  second operand, sampled with `start`
- `G`  out  word  registered result; holds until next completion
- `done`  out  1  one-cycle pulse: `G` and flags updated this cycle
- `busy`  out  1  high from accepted `start` until cycle of `done` (exclusive)
- `zf`  out  1  zero flag: `G` == 0
- `nf`  out  1  negative flag: `G[word-1]`
- `cf`  out  1  carry/borrow flag

## Operation
- Op codes: 000 NOP (`G`=0), 001 ADD (`A`+`bus`), 010 SUB (`A`−`bus`), 011 AND, 100 OR, 101 XOR, 110 SHL (`A` << `bus[log2(word)-1:0]`, zero fill), 111 MUL (low `word` bits of unsigned `A`×`bus`).
- `cf`: ADD = carry out of bit word−1; SUB = borrow (1 iff `A` < `bus` unsigned); all other ops 0.
- All arithmetic modulo 2^word; operands unsigned except `nf` interpretation.
- FSM states: IDLE, MUL, FIN.
  - IDLE: `start`=1 and op≠111 → compute, register `G`/flags, assert `done`, stay IDLE. `start`=1 and op=111 → latch operands, clear product, counter=0, go MUL.
  - MUL: each cycle, if multiplier LSB=1 add multiplicand to product; shift multiplicand left, multiplier right; counter++. After `word` iterations go FIN.
  - FIN: register product into `G`/flags, assert `done`, go IDLE.
- `start` while `busy`=1 is ignored (not queued); operands/op changes while busy have no effect.
- `start` in the same cycle `done` is asserted by FIN: FSM is in FIN, `busy`=0 is not yet true → ignored. Controller must issue after `done`.
- Flags and `G` change only in a `done` cycle; otherwise hold.
- Reset (any time, including mid-MUL): state IDLE, `G`=0, `done`=0, `busy`=0, `zf`=1, `nf`=0, `cf`=0, counter/product cleared; in-flight multiply discarded, no `done`.

## Timing
- Single-cycle ops: `start` sampled at edge k → `G`, flags, `done`=1 valid after edge k; `done` drops after edge k+1. Back-to-back `start` every cycle accepted (throughput 1/cycle).
- MUL: `start` at edge k → `busy`=1 after edge k; iterations at edges k+1..k+word; FIN after edge k+word; `G`/`done` valid after edge k+word+1; latency word+1 cycles (17 for word=16). `busy` falls with `done` rising.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `ALU_MUL_EN`: defined → op 111 is iterative multiply as above, MUL/FIN states and multiplier datapath present. Undefined → op 111 behaves as NOP (`G`=0, flags zf=1/nf=0/cf=0, single-cycle `done`), `busy` tied 0, no multiplier logic synthesised.

## Test plan
- Reset: assert `rst` mid-cycle with no clock → `G`=0, `zf`=1, `nf`=0, `cf`=0, `done`=0, `busy`=0 immediately.
- ADD/SUB: `A`=0xFFFF, `bus`=0x0001, ADD → next cycle `G`=0x0000, `zf`=1, `cf`=1, `done`=1; then SUB `A`=0x0003, `bus`=0x0005 → `G`=0xFFFE, `nf`=1, `cf`=1.
- Logic/shift back-to-back: AND 0xF0F0/0x0FF0 → 0x00F0; OR → 0xFFF0; XOR → 0xFF00; SHL `A`=0x8001 `bus`=0x0013 (shift 3) → 0x0008; one `done` per cycle, four consecutive.
- MUL (`ALU_MUL_EN` defined): `A`=0x0123, `bus`=0x0010 → `busy` 17 cycles... `done` exactly 17 cycles after `start`, `G`=0x1230; 0xFFFF×0xFFFF → `G`=0x0001; `start` pulses during `busy` ignored (single `done`).
- Reset mid-MUL: `rst` at iteration 8 → `busy`=0, no `done` ever appears; next ADD 2+3 → `G`=0x0005 after one cycle.
- `ALU_MUL_EN` undefined: op 111, `A`=0x0003, `bus`=0x0004 → one cycle later `G`=0x0000, `zf`=1, `done`=1, `busy` never asserted.
